// File: rtl/stall_flush_unit_pkg.sv
// Shared definitions for the pipeline stall/flush control unit:
// FSM state encoding, register constants and the control-bundle type.
package stall_flush_unit_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } sfu_state_e;

  localparam logic [4:0]  REG_X0              = 5'h00;
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 64;
  localparam int unsigned WAIT_CNT_W          = 8;

  // One bit per pipeline-register control line driven by the unit.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_NONE   = '0;
  localparam pipe_ctrl_t CTRL_FREEZE = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                                         stall_m: 1'b1, flush_d: 1'b0, flush_e: 1'b0,
                                         flush_w: 1'b1};
  localparam pipe_ctrl_t CTRL_BRANCH = '{stall_f: 1'b0, stall_d: 1'b0, stall_e: 1'b0,
                                         stall_m: 1'b0, flush_d: 1'b1, flush_e: 1'b1,
                                         flush_w: 1'b0};
  localparam pipe_ctrl_t CTRL_LOAD   = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b0,
                                         stall_m: 1'b0, flush_d: 1'b0, flush_e: 1'b1,
                                         flush_w: 1'b0};

  // A load in E whose destination is read by D; x0 never creates a dependence.
  function automatic logic is_load_use(input logic       is_load,
                                       input logic [4:0] rd_e,
                                       input logic [4:0] rs1_d,
                                       input logic [4:0] rs2_d);
    return is_load && (rd_e != REG_X0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
// Synchronous active-low reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/stall_flush_unit.sv
// Hazard control for the 5-stage RV32 pipe: load-use stalls, branch flushes,
// data-memory wait freeze with timeout, and saturating perf counters.
module stall_flush_unit
  import stall_flush_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ResultSrcE0,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushEvents
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  sfu_state_e             state, state_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt, wait_cnt_d;
  pipe_ctrl_t             ctrl;
  logic                   lw_stall;
  logic                   mem_wait;
  logic                   branch_flush;

  assign lw_stall = is_load_use(ResultSrcE0, RD_E, Rs1_D, Rs2_D);
  assign mem_wait = MemReqM && !MemReadyM;

  // Control outputs: a memory wait freezes everything (pending branch or
  // load-use is replayed after release); a branch beats a load-use because
  // the dependent instruction in D is being flushed anyway.
  // NOTE: every variable driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    ctrl         = CTRL_NONE;
    branch_flush = 1'b0;
    if (reset) begin
      if ((state == ERROR) || mem_wait) begin
        ctrl = CTRL_FREEZE;
      end else if (PCSrcE) begin
        ctrl         = CTRL_BRANCH;
        branch_flush = 1'b1;
      end else if (lw_stall) begin
        ctrl = CTRL_LOAD;
      end
    end
  end

  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_wait) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!mem_wait)                  state_d = RUN;
        else if (wait_cnt == WAIT_LAST) state_d = ERROR;
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    // Counts consecutive wait cycles; frozen once the error is latched.
    if (state != ERROR) begin
      wait_cnt_d = mem_wait ? (wait_cnt + WAIT_CNT_W'(1)) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (ctrl.stall_f && (state != ERROR)),
    .count (StallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (branch_flush),
    .count (FlushEvents)
  );

  assign StallF     = ctrl.stall_f;
  assign StallD     = ctrl.stall_d;
  assign StallE     = ctrl.stall_e;
  assign StallM     = ctrl.stall_m;
  assign FlushD     = ctrl.flush_d;
  assign FlushE     = ctrl.flush_e;
  assign FlushW     = ctrl.flush_w;
  assign MemTimeout = (state == ERROR);

endmodule

// File: tb/tb_stall_flush_unit.sv
// Self-checking bench for stall_flush_unit: directed hazard scenarios then
// randomized traffic, compared against a cycle-level behavioural model.
module tb_stall_flush_unit;

  localparam int T     = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          ResultSrcE0;
  logic [4:0]    RD_E, Rs1_D, Rs2_D;
  logic          PCSrcE, MemReqM, MemReadyM;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushW, MemTimeout;
  logic [CW-1:0] StallCycles, FlushEvents;

  int checks = 0;
  int errors = 0;

  // Model state: error latched, length of the current wait run, counters.
  bit m_err;
  int m_wait_len;
  int m_stall_cnt;
  int m_flush_cnt;

  always #5 clk = ~clk;

  stall_flush_unit #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .ResultSrcE0 (ResultSrcE0),
    .RD_E        (RD_E),
    .Rs1_D       (Rs1_D),
    .Rs2_D       (Rs2_D),
    .PCSrcE      (PCSrcE),
    .MemReqM     (MemReqM),
    .MemReadyM   (MemReadyM),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushW      (FlushW),
    .MemTimeout  (MemTimeout),
    .StallCycles (StallCycles),
    .FlushEvents (FlushEvents)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW} for this cycle.
  function automatic logic [6:0] model_ctrl();
    bit lw, mw;
    lw = ResultSrcE0 && (RD_E != 0) && (RD_E == Rs1_D || RD_E == Rs2_D);
    mw = MemReqM && !MemReadyM;
    if (!reset)           return 7'b0000000;
    if (m_err || mw)      return 7'b1111001;
    if (PCSrcE)           return 7'b0000110;
    if (lw)               return 7'b1100010;
    return 7'b0000000;
  endfunction

  // Compare outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    logic [6:0] exp_ctrl;
    exp_ctrl = model_ctrl();
    @(negedge clk);
    check("ctrl", {25'b0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW},
          {25'b0, exp_ctrl});
    if (reset) begin
      check("mem_timeout", {31'b0, MemTimeout}, {31'b0, m_err});
      check("stall_cycles", {28'b0, StallCycles}, m_stall_cnt);
      check("flush_events", {28'b0, FlushEvents}, m_flush_cnt);
    end
    @(posedge clk);
    if (!reset) begin
      m_err = 0; m_wait_len = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else if (!m_err) begin
      if (exp_ctrl[6])            m_stall_cnt = (m_stall_cnt < CMAX) ? m_stall_cnt + 1 : CMAX;
      if (exp_ctrl == 7'b0000110) m_flush_cnt = (m_flush_cnt < CMAX) ? m_flush_cnt + 1 : CMAX;
      if (MemReqM && !MemReadyM) begin
        m_wait_len++;
        if (m_wait_len == T) m_err = 1;
      end else begin
        m_wait_len = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    ResultSrcE0 = 0; RD_E = 0; Rs1_D = 0; Rs2_D = 0;
    PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic do_reset();
    reset = 0; cycle();
    reset = 1;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    cycle();
    cycle();
    reset = 1;
    cycle();
    check("rst_timeout", {31'b0, MemTimeout}, 32'd0);
    check("rst_stall_cnt", {28'b0, StallCycles}, 32'd0);

    // Load-use: exactly one bubble.
    ResultSrcE0 = 1; RD_E = 5; Rs1_D = 1; Rs2_D = 5;
    cycle();
    idle_inputs();
    cycle();
    check("lu_count", {28'b0, StallCycles}, 32'd1);

    // Load into x0 is never a hazard.
    ResultSrcE0 = 1; RD_E = 0; Rs1_D = 0; Rs2_D = 3;
    cycle();

    // Branch beats load-use.
    ResultSrcE0 = 1; RD_E = 7; Rs1_D = 7; Rs2_D = 2; PCSrcE = 1;
    cycle();
    idle_inputs();
    cycle();
    check("br_count", {28'b0, FlushEvents}, 32'd1);
    check("br_no_stall", {28'b0, StallCycles}, 32'd1);

    // Three wait cycles, release in the ready cycle.
    MemReqM = 1; MemReadyM = 0;
    repeat (3) cycle();
    MemReadyM = 1;
    cycle();
    idle_inputs();
    cycle();
    check("wait_count", {28'b0, StallCycles}, 32'd4);

    // Pending branch is held during a 2-cycle wait, flushed on ready.
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    repeat (2) cycle();
    MemReadyM = 1;
    cycle();
    idle_inputs();
    cycle();
    check("wbr_flush_count", {28'b0, FlushEvents}, 32'd2);

    // Timeout: ready never comes.
    MemReqM = 1; MemReadyM = 0;
    repeat (T + 3) cycle();
    check("timeout_flag", {31'b0, MemTimeout}, 32'd1);
    idle_inputs();
    cycle();
    check("error_sticky", {31'b0, MemTimeout}, 32'd1);
    do_reset();
    cycle();
    check("post_rst_timeout", {31'b0, MemTimeout}, 32'd0);
    check("post_rst_flush", {28'b0, FlushEvents}, 32'd0);

    // Saturation: 20 stall cycles on a 4-bit counter.
    ResultSrcE0 = 1; RD_E = 9; Rs1_D = 9; Rs2_D = 0;
    repeat (20) cycle();
    idle_inputs();
    cycle();
    check("sat_count", {28'b0, StallCycles}, CMAX);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 40) != 0);
      ResultSrcE0 = 1'($urandom_range(0, 1));
      RD_E        = 5'($urandom_range(0, 3));
      Rs1_D       = 5'($urandom_range(0, 3));
      Rs2_D       = 5'($urandom_range(0, 3));
      PCSrcE      = ($urandom_range(0, 3) == 0);
      MemReqM     = ($urandom_range(0, 2) == 0);
      MemReadyM   = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
